// File: rtl/ling_pkg.sv
// Shared definitions for the Ling adder/subtractor family: default widths,
// configuration check and the pseudo-carry (h) builder.
package ling_pkg;

  localparam int N_DEF      = 64;
  localparam int K_DEF      = 16;
  localparam int LING_MAX_W = 64;

  function automatic bit cfg_ok(input int n, input int k);
    return (k > 0) && (k <= LING_MAX_W) && (n >= k) && ((n % k) == 0);
  endfunction

  // h[0] is the slice carry-in; h[i+1] = g[i] | p[i-1] & h[i] with p[-1] = 1,
  // so the true carry into bit i is h[i] & p[i-1].
  function automatic logic [LING_MAX_W:0] ling_h(input logic [LING_MAX_W-1:0] p,
                                                 input logic [LING_MAX_W-1:0] g,
                                                 input logic                  cin);
    logic [LING_MAX_W:0] h;
    logic                pm;
    h[0] = cin;
    pm   = 1'b1;
    for (int i = 0; i < LING_MAX_W; i++) begin
      h[i+1] = g[i] | (pm & h[i]);
      pm     = p[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/ling_sub_slice.sv
// Combinational K-bit Ling slice computing a + ~b + cin, with carry-out and
// the signed-overflow flag for the slice's top bit.
module ling_sub_slice
  import ling_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] diff,
  output logic         cout,
  output logic         sign_ovf
);

  logic [K-1:0]          bn, p, g, c;
  logic [LING_MAX_W-1:0] pw, gw;
  logic [LING_MAX_W:0]   h;

  assign bn = ~b;
  assign p  = a | bn;
  assign g  = a & bn;

  always_comb begin
    pw        = '0;
    gw        = '0;
    pw[K-1:0] = p;
    gw[K-1:0] = g;
  end

  assign h = ling_h(pw, gw, cin);

  always_comb begin
    c    = '0;
    c[0] = h[0];
    for (int i = 1; i < K; i++) begin
      c[i] = h[i] & p[i-1];
    end
  end

  assign diff     = p ^ g ^ c;
  assign cout     = h[K] & p[K-1];
  assign sign_ovf = (a[K-1] ^ b[K-1]) & (diff[K-1] ^ a[K-1]);

  if (K < LING_MAX_W) begin : g_pad
    logic unused_h;
    assign unused_h = ^h[LING_MAX_W:K+1];
  end

endmodule

// File: rtl/ling_sub_pipe.sv
// Pipelined a - b - bin: one registered Ling slice per stage, operands skewed
// forward and finished result slices carried along; whole-pipe stall on back-pressure.
module ling_sub_pipe
  import ling_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_diff,
  output logic         out_bout,
  output logic         out_ovf
);

  localparam int S = N / K;

  if (!cfg_ok(N, K)) begin : g_cfg_err
    $error("ling_sub_pipe: N must be a nonzero multiple of K and K <= %0d", LING_MAX_W);
  end

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar j = 0; j < S; j++) begin : stg
    localparam int W_SRC = N - j * K;

    logic [W_SRC-1:0]     a_src, b_src;
    logic                 cin, vin, co, sovf;
    logic [K-1:0]         sd;
    logic [(j+1)*K-1:0]   res_nxt, res_p;
    logic                 carry_p;
    logic                 vld_p;

    // stage j inputs: operand slices not yet consumed, carry and valid from stage j-1
    if (j == 0) begin : g_src
      assign a_src   = in_a;
      assign b_src   = in_b;
      assign cin     = ~in_bin;
      assign vin     = in_valid;
      assign res_nxt = sd;
    end else begin : g_src
      assign a_src   = stg[j-1].g_skew.a_p;
      assign b_src   = stg[j-1].g_skew.b_p;
      assign cin     = stg[j-1].carry_p;
      assign vin     = stg[j-1].vld_p;
      assign res_nxt = {sd, stg[j-1].res_p};
    end

    ling_sub_slice #(.K(K)) u_slice (
      .a        (a_src[K-1:0]),
      .b        (b_src[K-1:0]),
      .cin      (cin),
      .diff     (sd),
      .cout     (co),
      .sign_ovf (sovf)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      vld_p <= 1'b0;
      else if (adv) vld_p <= vin;
    end

    if (j < S - 1) begin : g_skew
      logic [W_SRC-K-1:0] a_p, b_p;
      always_ff @(posedge clk) begin
        if (adv) begin
          a_p <= a_src[W_SRC-1:K];
          b_p <= b_src[W_SRC-1:K];
        end
      end
    end

    // last stage drives the outputs, so its data is cleared by reset
    if (j == S - 1) begin : g_out
      logic ovf_p;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_p   <= '0;
          carry_p <= 1'b1;
          ovf_p   <= 1'b0;
        end else if (adv) begin
          res_p   <= res_nxt;
          carry_p <= co;
          ovf_p   <= sovf;
        end
      end
    end else begin : g_mid
      logic unused_ovf;
      assign unused_ovf = sovf;
      always_ff @(posedge clk) begin
        if (adv) begin
          res_p   <= res_nxt;
          carry_p <= co;
        end
      end
    end
  end

  assign out_valid = stg[S-1].vld_p;
  assign out_diff  = stg[S-1].res_p;
  assign out_bout  = ~stg[S-1].carry_p;
  assign out_ovf   = stg[S-1].g_out.ovf_p;

endmodule

// File: tb/tb_ling_sub_pipe.sv
// Self-checking bench for ling_sub_pipe (N=64, K=16): directed corner cases,
// randomized traffic against a wide-arithmetic model, back-pressure and reset.
module tb_ling_sub_pipe;

  localparam int N = 64;
  localparam int K = 16;
  localparam int S = N / K;

  typedef struct {
    logic [63:0] d;
    logic        b;
    logic        o;
  } exp_t;

  logic         clk, rst;
  logic         in_valid, in_ready, in_bin;
  logic [N-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_bout, out_ovf;
  logic [N-1:0] out_diff;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];

  ling_sub_pipe #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
    localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MINS = -MAXS - 66'sd1;
    logic signed [65:0] sd;
    exp_t r;
    r.d = a - b - 64'(bi);
    r.b = ({1'b0, a} < ({1'b0, b} + 65'(bi)));
    sd  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'b0, bi});
    r.o = (sd > MAXS) || (sd < MINS);
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bi, input exp_t e);
    int w;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_bin   = bi;
    w        = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] a, b;
    logic        bi;
    a  = pick();
    b  = pick();
    bi = 1'($urandom_range(0, 1));
    send(a, b, bi, model(a, b, bi));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard, stall stability and in_ready rule.
  initial begin
    logic        stall_prev;
    logic [63:0] hd;
    logic        hb, ho;
    exp_t        e;
    stall_prev = 1'b0;
    hd = '0; hb = 1'b0; ho = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (stall_prev) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_diff", out_diff, hd);
          check("stall_bout", 64'(out_bout), 64'(hb));
          check("stall_ovf", 64'(out_ovf), 64'(ho));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_result", 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            check("diff", out_diff, e.d);
            check("bout", 64'(out_bout), 64'(e.b));
            check("ovf", 64'(out_ovf), 64'(e.o));
          end
        end
        stall_prev = out_valid && !out_ready;
        hd = out_diff; hb = out_bout; ho = out_ovf;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_bin    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_diff", out_diff, 64'd0);
    check("rst_bout", 64'(out_bout), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic difference plus latency from the accepting edge
    e = '{d: 64'd15, b: 1'b0, o: 1'b0};
    send(64'd25, 64'd10, 1'b0, e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 64'(lat), 64'(S));
    drain();

    // directed corners with hand-computed results
    e = '{d: 64'hFFFF_FFFF_FFFF_FFFF, b: 1'b1, o: 1'b0};
    send(64'd0, 64'd1, 1'b0, e);
    e = '{d: 64'hFFFF_FFFF_FFFF_FFFE, b: 1'b1, o: 1'b0};
    send(64'd0, 64'd1, 1'b1, e);
    e = '{d: 64'h7FFF_FFFF_FFFF_FFFF, b: 1'b0, o: 1'b1};
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, e);
    e = '{d: 64'h0000_FFFF_FFFF_FFFF, b: 1'b0, o: 1'b0};
    send(64'h0001_0000_0000_0000, 64'd1, 1'b0, e);
    e = '{d: 64'h8000_0000_0000_0000, b: 1'b1, o: 1'b1};
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, e);
    drain();

    // back-pressure: 8 back-to-back beats, out_ready toggling 1,0,1,0...
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        for (int i = 0; i < 30; i++) begin
          out_ready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand();
      end
      begin
        for (int i = 0; i < 120; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // full-rate burst
    for (int i = 0; i < 20; i++) send_rand();
    drain();

    // reset with beats in flight
    for (int i = 0; i < 3; i++) send_rand();
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_diff", out_diff, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(out_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    e = '{d: 64'd15, b: 1'b0, o: 1'b0};
    send(64'd25, 64'd10, 1'b0, e);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
